// File: rtl/multdiv_sched.sv
// Round-robin scheduler sharing one multdiv unit between two requesters.
// One operation in flight; operands held stable, result returned on resultRDY or timeout.
module multdiv_sched #(
    parameter int unsigned TAG_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,

    input  logic             req0_valid,
    input  logic             req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic             req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_result,
    output logic             resp_exception,
    output logic             resp_timeout,

    output logic [31:0]      md_operandA,
    output logic [31:0]      md_operandB,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    input  logic [31:0]      md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,

    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_t;

    state_t           r_state;
    logic             r_rr_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_id;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_operand_a;
    logic [31:0]      r_operand_b;
    logic             r_ctrl_mult;
    logic             r_ctrl_div;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [TAG_W-1:0] r_resp_tag;
    logic [31:0]      r_resp_result;
    logic             r_resp_exception;
    logic             r_resp_timeout;

    logic             w_idle;
    logic             w_any_valid;
    logic             w_grant_id;
    logic             w_grant_op;
    logic [31:0]      w_grant_a;
    logic [31:0]      w_grant_b;
    logic [TAG_W-1:0] w_grant_tag;

    assign w_idle      = (r_state == StIdle);
    assign w_any_valid = req0_valid | req1_valid;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_rr_last;
        end else begin
            w_grant_id = req1_valid;
        end
    end

    assign w_grant_op  = w_grant_id ? req1_op  : req0_op;
    assign w_grant_a   = w_grant_id ? req1_a   : req0_a;
    assign w_grant_b   = w_grant_id ? req1_b   : req0_b;
    assign w_grant_tag = w_grant_id ? req1_tag : req0_tag;

    assign req0_ready = w_idle & w_any_valid & ~w_grant_id;
    assign req1_ready = w_idle & w_any_valid & w_grant_id;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_state          <= StIdle;
            r_rr_last        <= 1'b1;
            r_cnt            <= '0;
            r_id             <= 1'b0;
            r_tag            <= '0;
            r_operand_a      <= '0;
            r_operand_b      <= '0;
            r_ctrl_mult      <= 1'b0;
            r_ctrl_div       <= 1'b0;
            r_resp_valid     <= 1'b0;
            r_resp_id        <= 1'b0;
            r_resp_tag       <= '0;
            r_resp_result    <= '0;
            r_resp_exception <= 1'b0;
            r_resp_timeout   <= 1'b0;
        end else begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_any_valid) begin
                        r_id        <= w_grant_id;
                        r_tag       <= w_grant_tag;
                        r_operand_a <= w_grant_a;
                        r_operand_b <= w_grant_b;
                        r_rr_last   <= w_grant_id;
                        // Start pulse is registered so it lands exactly in the ISSUE cycle.
                        r_ctrl_mult <= ~w_grant_op;
                        r_ctrl_div  <= w_grant_op;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    r_cnt   <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (md_resultRDY) begin
                        r_resp_valid     <= 1'b1;
                        r_resp_id        <= r_id;
                        r_resp_tag       <= r_tag;
                        r_resp_result    <= md_result;
                        r_resp_exception <= md_exception;
                        r_resp_timeout   <= 1'b0;
                        r_state          <= StResp;
                    end else if (r_cnt == CNT_LAST) begin
                        r_resp_valid     <= 1'b1;
                        r_resp_id        <= r_id;
                        r_resp_tag       <= r_tag;
                        r_resp_result    <= '0;
                        r_resp_exception <= 1'b1;
                        r_resp_timeout   <= 1'b1;
                        r_state          <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign resp_valid     = r_resp_valid;
    assign resp_id        = r_resp_id;
    assign resp_tag       = r_resp_tag;
    assign resp_result    = r_resp_result;
    assign resp_exception = r_resp_exception;
    assign resp_timeout   = r_resp_timeout;
    assign md_operandA    = r_operand_a;
    assign md_operandB    = r_operand_b;
    assign md_ctrl_MULT   = r_ctrl_mult;
    assign md_ctrl_DIV    = r_ctrl_div;
    assign busy           = ~w_idle;

endmodule

// File: tb/tb_multdiv_sched.sv
// Bench for multdiv_sched: behavioural multdiv stand-in plus a reference of the
// scheduling rules (round-robin, latency, timeout) checked with immediate assertions.
module tb_multdiv_sched;

    localparam int TAG_W = 4;
    localparam int TMO   = 64;

    logic              clock;
    logic              ctrl_reset_n;
    logic              req0_valid, req0_op, req0_ready;
    logic [31:0]       req0_a, req0_b;
    logic [TAG_W-1:0]  req0_tag;
    logic              req1_valid, req1_op, req1_ready;
    logic [31:0]       req1_a, req1_b;
    logic [TAG_W-1:0]  req1_tag;
    logic              resp_valid, resp_ready, resp_id, resp_exception, resp_timeout;
    logic [TAG_W-1:0]  resp_tag;
    logic [31:0]       resp_result;
    logic [31:0]       md_operandA, md_operandB, md_result;
    logic              md_ctrl_MULT, md_ctrl_DIV, md_exception, md_resultRDY;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // multdiv stand-in controls
    int m_cnt;
    int m_delay  = 0;
    bit m_never  = 0;
    bit m_manual = 0;

    typedef struct {
        bit              port;
        bit              op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];

    multdiv_sched #(
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .ctrl_reset_n   (ctrl_reset_n),
        .req0_valid     (req0_valid),
        .req0_op        (req0_op),
        .req0_a         (req0_a),
        .req0_b         (req0_b),
        .req0_tag       (req0_tag),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_op        (req1_op),
        .req1_a         (req1_a),
        .req1_b         (req1_b),
        .req1_tag       (req1_tag),
        .req1_ready     (req1_ready),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_tag       (resp_tag),
        .resp_result    (resp_result),
        .resp_exception (resp_exception),
        .resp_timeout   (resp_timeout),
        .md_operandA    (md_operandA),
        .md_operandB    (md_operandB),
        .md_ctrl_MULT   (md_ctrl_MULT),
        .md_ctrl_DIV    (md_ctrl_DIV),
        .md_result      (md_result),
        .md_exception   (md_exception),
        .md_resultRDY   (md_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Arithmetic meaning of an operation; a timeout forces result 0 with exception.
    function automatic void ref_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                                   input bit to, output logic [31:0] r, output logic e);
        if (to) begin
            r = '0;
            e = 1'b1;
        end else if (!op) begin
            r = a * b;
            e = 1'b0;
        end else if (b == 32'd0) begin
            r = '0;
            e = 1'b1;
        end else begin
            r = $signed(a) / $signed(b);
            e = 1'b0;
        end
    endfunction

    // multdiv stand-in: computes from the operands the scheduler presents, answers
    // m_delay WAIT cycles after the start pulse (or never).
    initial begin
        logic [31:0] r;
        logic        e;
        md_result    = '0;
        md_exception = 1'b0;
        md_resultRDY = 1'b0;
        m_cnt        = -1;
        forever begin
            @(posedge clock);
            #1;
            md_resultRDY = 1'b0;
            if (md_ctrl_MULT || md_ctrl_DIV) begin
                ref_op(md_ctrl_DIV, md_operandA, md_operandB, 1'b0, r, e);
                md_result    = r;
                md_exception = e;
                m_cnt        = m_never ? -1 : m_delay;
            end else if (m_cnt == 0) begin
                md_resultRDY = 1'b1;
                m_cnt        = -1;
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end
            if (m_manual) md_resultRDY = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] expected);
        checks++;
        assert (obs === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 128'({req0_ready, req1_ready, resp_valid, resp_id, resp_tag, resp_result,
                        resp_exception, resp_timeout, md_operandA, md_operandB,
                        md_ctrl_MULT, md_ctrl_DIV, busy}), 128'(0));
    endtask

    task automatic do_reset();
        ctrl_reset_n = 1'b0;
        req0_valid   = 1'b0;
        req1_valid   = 1'b0;
        resp_ready   = 1'b0;
        cyc();
        cyc();
        #1;
        chk_all_zero("reset_state");
        ctrl_reset_n = 1'b1;
        cyc();
    endtask

    task automatic start_req(input bit port, input bit op, input logic [31:0] a,
                             input logic [31:0] b, input logic [TAG_W-1:0] tag);
        if (port) begin
            req1_op = op; req1_a = a; req1_b = b; req1_tag = tag; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_tag = tag; req0_valid = 1'b1;
        end
    endtask

    task automatic expect_accept(input bit port);
        #1;
        chk("ready_grant", 128'({req1_ready, req0_ready}), port ? 128'(2'b10) : 128'(2'b01));
        cyc();
        if (port) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
    endtask

    task automatic expect_issue(input bit op, input logic [31:0] a, input logic [31:0] b);
        chk("issue_busy", 128'(busy), 128'(1));
        chk("issue_pulse", 128'({md_ctrl_DIV, md_ctrl_MULT}), op ? 128'(2'b10) : 128'(2'b01));
        chk("issue_operands", 128'({md_operandA, md_operandB}), 128'({a, b}));
    endtask

    task automatic expect_resp(input bit port, input bit op, input logic [31:0] a,
                               input logic [31:0] b, input logic [TAG_W-1:0] tag,
                               input int delay, input bit never, input int hold);
        int          waits;
        int          exp_waits;
        bit          to;
        logic [31:0] er;
        logic        ee;
        to        = never || (delay >= TMO);
        exp_waits = to ? TMO : delay + 1;
        ref_op(op, a, b, to, er, ee);
        waits = 0;
        cyc();
        chk("single_pulse", 128'({md_ctrl_DIV, md_ctrl_MULT}), 128'(0));
        while (!resp_valid && waits < 200) begin
            waits++;
            cyc();
        end
        chk("wait_cycles", 128'(waits), 128'(exp_waits));
        chk("resp_fields", 128'({resp_valid, resp_id, resp_tag, resp_result, resp_exception,
                                 resp_timeout}), 128'({1'b1, port, tag, er, ee, to}));
        chk("resp_operands_held", 128'({md_operandA, md_operandB, busy}), 128'({a, b, 1'b1}));
        for (int i = 0; i < hold; i++) begin
            cyc();
            chk("hold_stable", 128'({resp_valid, resp_id, resp_tag, resp_result, resp_exception,
                                     resp_timeout}), 128'({1'b1, port, tag, er, ee, to}));
            chk("hold_no_accept", 128'({req1_ready, req0_ready, md_ctrl_DIV, md_ctrl_MULT}),
                128'(0));
        end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk("after_handshake", 128'({resp_valid, busy}), 128'(0));
    endtask

    initial begin
        logic [31:0]      a, b, a2, b2;
        logic [TAG_W-1:0] tag;
        bit               port, op, rr_last, exp_p, accepted;
        int               delay, hold, n_acc, n_resp;
        logic [31:0]      pa[2], pb[2];
        bit               pop[2];
        logic [TAG_W-1:0] ptag[2];
        exp_t             e;
        logic [31:0]      er;
        logic             ee;

        ctrl_reset_n = 1'b0;
        req0_valid = 1'b0; req0_op = 1'b0; req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_a = '0; req1_b = '0; req1_tag = '0;
        resp_ready = 1'b0;
        do_reset();

        // Port 0 multiply 7 * -6
        m_never = 0; m_delay = 32;
        start_req(0, 0, 32'd7, 32'hFFFF_FFFA, 4'd3);
        expect_accept(0);
        expect_issue(0, 32'd7, 32'hFFFF_FFFA);
        expect_resp(0, 0, 32'd7, 32'hFFFF_FFFA, 4'd3, 32, 0, 0);

        // Port 1 divide by zero
        m_delay = 5;
        start_req(1, 1, 32'd5, 32'd0, 4'd9);
        expect_accept(1);
        expect_issue(1, 32'd5, 32'd0);
        expect_resp(1, 1, 32'd5, 32'd0, 4'd9, 5, 0, 0);

        // No resultRDY ever, then resultRDY on the final WAIT cycle
        m_never = 1;
        a = $urandom; b = $urandom;
        start_req(0, 0, a, b, 4'd12);
        expect_accept(0);
        expect_issue(0, a, b);
        expect_resp(0, 0, a, b, 4'd12, 0, 1, 0);
        m_never = 0; m_delay = TMO - 1;
        start_req(1, 0, a, b, 4'd1);
        expect_accept(1);
        expect_issue(0, a, b);
        expect_resp(1, 0, a, b, 4'd1, TMO - 1, 0, 0);

        // resultRDY while idle is ignored
        m_manual = 1;
        cyc();
        m_manual = 0;
        cyc();
        chk("idle_rdy_ignored", 128'({busy, resp_valid}), 128'(0));

        // Response back-pressure with a pending port-0 request
        m_delay = 4;
        a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
        start_req(1, 0, a, b, 4'd9);
        expect_accept(1);
        expect_issue(0, a, b);
        start_req(0, 1, a2, b2, 4'd6);
        expect_resp(1, 0, a, b, 4'd9, 4, 0, 10);
        m_delay = 3;
        expect_accept(0);
        expect_issue(1, a2, b2);
        expect_resp(0, 1, a2, b2, 4'd6, 3, 0, 0);

        // Randomized single-port operations
        for (int i = 0; i < 8; i++) begin
            port  = 1'($urandom_range(0, 1));
            op    = 1'($urandom_range(0, 1));
            a     = $urandom;
            b     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            tag   = TAG_W'($urandom);
            delay = int'($urandom_range(0, 20));
            hold  = int'($urandom_range(0, 2));
            m_delay = delay;
            start_req(port, op, a, b, tag);
            expect_accept(port);
            expect_issue(op, a, b);
            expect_resp(port, op, a, b, tag, delay, 0, hold);
        end

        // Both ports valid continuously from reset: grants must alternate 0,1,0,1
        do_reset();
        resp_ready = 1'b1;
        m_delay = 1;
        for (int p = 0; p < 2; p++) begin
            pop[p] = 1'($urandom_range(0, 1)); pa[p] = $urandom;
            pb[p] = $urandom_range(1, 5000); ptag[p] = TAG_W'($urandom);
        end
        start_req(0, pop[0], pa[0], pb[0], ptag[0]);
        start_req(1, pop[1], pa[1], pb[1], ptag[1]);
        rr_last = 1'b1; n_acc = 0; n_resp = 0; exp_p = 1'b0;
        for (int c = 0; c < 300 && n_resp < 4; c++) begin
            #1;
            accepted = 1'b0;
            if (!busy && n_acc < 4) begin
                exp_p = ~rr_last;
                chk("rr_grant", 128'({req1_ready, req0_ready}),
                    exp_p ? 128'(2'b10) : 128'(2'b01));
                e.port = exp_p; e.op = pop[exp_p]; e.a = pa[exp_p]; e.b = pb[exp_p];
                e.tag = ptag[exp_p];
                q.push_back(e);
                rr_last  = exp_p;
                n_acc++;
                accepted = 1'b1;
            end else begin
                chk("rr_ready_low", 128'({req1_ready, req0_ready}), 128'(0));
            end
            if (resp_valid) begin
                chk("rr_resp_expected", 128'(q.size() != 0), 128'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    ref_op(e.op, e.a, e.b, 1'b0, er, ee);
                    chk("rr_resp", 128'({resp_id, resp_tag, resp_result, resp_exception,
                                         resp_timeout}), 128'({e.port, e.tag, er, ee, 1'b0}));
                    n_resp++;
                end
            end
            cyc();
            if (accepted) begin
                if (n_acc == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end else begin
                    pop[exp_p] = 1'($urandom_range(0, 1)); pa[exp_p] = $urandom;
                    pb[exp_p] = $urandom_range(1, 5000); ptag[exp_p] = TAG_W'($urandom);
                    start_req(exp_p, pop[exp_p], pa[exp_p], pb[exp_p], ptag[exp_p]);
                end
            end
        end
        chk("rr_resp_count", 128'(n_resp), 128'(4));
        resp_ready = 1'b0;

        // Reset in the middle of WAIT, late resultRDY after release
        m_never = 1;
        start_req(0, 1, 32'd100, 32'd7, 4'd5);
        expect_accept(0);
        expect_issue(1, 32'd100, 32'd7);
        cyc();
        cyc();
        chk("midwait_busy", 128'(busy), 128'(1));
        ctrl_reset_n = 1'b0;
        #1;
        chk_all_zero("reset_midwait");
        cyc();
        cyc();
        ctrl_reset_n = 1'b1;
        cyc();
        m_manual = 1;
        cyc();
        m_manual = 0;
        chk_all_zero("late_rdy_cycle");
        cyc();
        chk_all_zero("late_rdy_ignored");
        cyc();
        chk_all_zero("late_rdy_settled");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
